// File: rtl/cpu16_mem_pkg.sv
// Shared types and constants for the cpu16 memory arbiter: address regions,
// the fill value for unmapped reads and the registered read-source tag.
package cpu16_mem_pkg;

    localparam logic [3:0]  REGION_SRAM = 4'h0;
    localparam logic [3:0]  REGION_VRAM = 4'h8;
    localparam logic [3:0]  REGION_CTRL = 4'hF;
    localparam logic [15:0] READ_FILL   = 16'hEEEE;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_INS_SRAM,
        SRC_DAT_SRAM,
        SRC_DAT_CONST
    } read_src_e;

    function automatic logic [3:0] region_of(input logic [15:0] addr);
        return addr[15:12];
    endfunction

endpackage

// File: rtl/cpu16_mem_arbiter_arb_rr2.sv
// Two-requester grant picker for the SRAM read port (ins vs. dat).
// CPU16_ARB_ROUND_ROBIN_EN selects round-robin; otherwise dat has fixed priority.
module arb_rr2 (
    input  logic clk,
    input  logic reset_n,
    input  logic ins_req,
    input  logic dat_req,
    output logic ins_gnt,
    output logic dat_gnt
);

`ifdef CPU16_ARB_ROUND_ROBIN_EN
    logic last_ins;
    logic contested;

    assign contested = ins_req & dat_req;

    // Pointer only moves on contested cycles; reset value lets ins win first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_ins <= 1'b0;
        end else if (contested) begin
            last_ins <= ~last_ins;
        end
    end

    always_comb begin
        ins_gnt = ins_req & (~dat_req | ~last_ins);
        dat_gnt = dat_req & (~ins_req |  last_ins);
    end
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ reset_n;

    always_comb begin
        dat_gnt = dat_req;
        ins_gnt = ins_req & ~dat_req;
    end
`endif

endmodule

// File: rtl/cpu16_mem_arbiter.sv
// Shared-memory responder for cpu16: arbitrates ins reads, data reads/writes
// and debug writes onto SRAM, VRAM and the control register (holds cpu_reset).
// Optional macro: CPU16_ARB_ROUND_ROBIN_EN (round-robin read-port arbitration).
module cpu16_mem_arbiter
    import cpu16_mem_pkg::*;
#(
    parameter int SRAM_AW = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [15:0]        ins_rd_addr,
    input  logic               ins_rd_req,
    output logic [15:0]        ins_rd_data,
    output logic               ins_rd_rdy,
    input  logic [15:0]        dat_rw_addr,
    input  logic [15:0]        dat_wr_data,
    input  logic               dat_rd_req,
    input  logic               dat_wr_req,
    output logic [15:0]        dat_rd_data,
    output logic               dat_rd_rdy,
    output logic               dat_wr_rdy,
    input  logic               dbg_we,
    input  logic [15:0]        dbg_waddr,
    input  logic [15:0]        dbg_wdata,
    output logic [SRAM_AW-1:0] mem_raddr,
    output logic               mem_re,
    input  logic [15:0]        mem_rdata,
    output logic [SRAM_AW-1:0] mem_waddr,
    output logic [15:0]        mem_wdata,
    output logic               mem_we,
    output logic [10:0]        vram_waddr,
    output logic [7:0]         vram_wdata,
    output logic               vram_we,
    output logic               cpu_reset
);

    logic        cpu_en;
    logic        dat_wr_gnt;
    logic        wr_active;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  wr_region;
    logic        ctrl_we;
    logic        ins_cand;
    logic        dat_rd_cand;
    logic        dat_rd_sram;
    logic        dat_rd_const;
    logic        ins_gnt;
    logic        dat_sram_gnt;
    logic [15:0] const_val;

    read_src_e   ins_src_q;
    read_src_e   dat_src_q;
    logic [15:0] const_q;
    logic        dat_wr_rdy_q;
    logic        unused_addr_bits;

    assign cpu_en = ~cpu_reset;

    // Write port: debug always wins and is accepted even while the CPU is held.
    always_comb begin
        dat_wr_gnt = dat_wr_req & ~dbg_we & cpu_en;
        wr_active  = dbg_we | dat_wr_gnt;
        wr_addr    = dbg_we ? dbg_waddr : dat_rw_addr;
        wr_data    = dbg_we ? dbg_wdata : dat_wr_data;
        wr_region  = region_of(wr_addr);
        mem_we     = wr_active && (wr_region == REGION_SRAM);
        vram_we    = wr_active && (wr_region == REGION_VRAM);
        ctrl_we    = wr_active && (wr_region == REGION_CTRL);
    end

    assign mem_waddr  = wr_addr[SRAM_AW-1:0];
    assign mem_wdata  = wr_data;
    assign vram_waddr = wr_addr[10:0];
    assign vram_wdata = wr_data[7:0];

    // A pending data write blocks the data read; non-SRAM reads bypass the port.
    always_comb begin
        ins_cand     = ins_rd_req & cpu_en;
        dat_rd_cand  = dat_rd_req & ~dat_wr_req & cpu_en;
        dat_rd_sram  = dat_rd_cand && (region_of(dat_rw_addr) == REGION_SRAM);
        dat_rd_const = dat_rd_cand && (region_of(dat_rw_addr) != REGION_SRAM);
        const_val    = (region_of(dat_rw_addr) == REGION_CTRL) ? {15'b0, cpu_reset}
                                                                : READ_FILL;
    end

    arb_rr2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .ins_req (ins_cand),
        .dat_req (dat_rd_sram),
        .ins_gnt (ins_gnt),
        .dat_gnt (dat_sram_gnt)
    );

    assign mem_re    = ins_gnt | dat_sram_gnt;
    assign mem_raddr = ins_gnt ? ins_rd_addr[SRAM_AW-1:0] : dat_rw_addr[SRAM_AW-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ins_src_q    <= SRC_NONE;
            dat_src_q    <= SRC_NONE;
            const_q      <= 16'h0000;
            dat_wr_rdy_q <= 1'b0;
            cpu_reset    <= 1'b0;
        end else begin
            ins_src_q    <= ins_gnt ? SRC_INS_SRAM : SRC_NONE;
            dat_src_q    <= dat_sram_gnt ? SRC_DAT_SRAM :
                            dat_rd_const ? SRC_DAT_CONST : SRC_NONE;
            const_q      <= dat_rd_const ? const_val : 16'h0000;
            dat_wr_rdy_q <= dat_wr_gnt;
            if (ctrl_we) begin
                cpu_reset <= wr_data[0];
            end
        end
    end

    // Completion pulses scheduled before cpu_reset rose are swallowed here.
    always_comb begin
        ins_rd_rdy  = (ins_src_q == SRC_INS_SRAM) & cpu_en;
        dat_rd_rdy  = (dat_src_q != SRC_NONE) & cpu_en;
        dat_wr_rdy  = dat_wr_rdy_q & cpu_en;
        ins_rd_data = (ins_src_q == SRC_INS_SRAM) ? mem_rdata : 16'h0000;
        case (dat_src_q)
            SRC_DAT_SRAM:  dat_rd_data = mem_rdata;
            SRC_DAT_CONST: dat_rd_data = const_q;
            default:       dat_rd_data = 16'h0000;
        endcase
    end

    assign unused_addr_bits = ^{wr_addr, ins_rd_addr};

endmodule

// File: tb/tb_cpu16_mem_arbiter.sv
// Directed testbench for cpu16_mem_arbiter with a behavioural 256x16 SRAM.
// Expectations follow CPU16_ARB_ROUND_ROBIN_EN when it is defined.
module tb_cpu16_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] ins_rd_addr = 16'h0;
    logic        ins_rd_req = 1'b0;
    logic [15:0] ins_rd_data;
    logic        ins_rd_rdy;
    logic [15:0] dat_rw_addr = 16'h0;
    logic [15:0] dat_wr_data = 16'h0;
    logic        dat_rd_req = 1'b0;
    logic        dat_wr_req = 1'b0;
    logic [15:0] dat_rd_data;
    logic        dat_rd_rdy;
    logic        dat_wr_rdy;
    logic        dbg_we = 1'b0;
    logic [15:0] dbg_waddr = 16'h0;
    logic [15:0] dbg_wdata = 16'h0;
    logic [7:0]  mem_raddr;
    logic        mem_re;
    logic [15:0] mem_rdata = 16'h0;
    logic [7:0]  mem_waddr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [10:0] vram_waddr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic        cpu_reset;

    logic [15:0] sram [0:255];
    int          check_cnt = 0;
    int          pass_cnt  = 0;

    always #5 clk = ~clk;

    cpu16_mem_arbiter #(.SRAM_AW(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ins_rd_addr (ins_rd_addr),
        .ins_rd_req  (ins_rd_req),
        .ins_rd_data (ins_rd_data),
        .ins_rd_rdy  (ins_rd_rdy),
        .dat_rw_addr (dat_rw_addr),
        .dat_wr_data (dat_wr_data),
        .dat_rd_req  (dat_rd_req),
        .dat_wr_req  (dat_wr_req),
        .dat_rd_data (dat_rd_data),
        .dat_rd_rdy  (dat_rd_rdy),
        .dat_wr_rdy  (dat_wr_rdy),
        .dbg_we      (dbg_we),
        .dbg_waddr   (dbg_waddr),
        .dbg_wdata   (dbg_wdata),
        .mem_raddr   (mem_raddr),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .vram_waddr  (vram_waddr),
        .vram_wdata  (vram_wdata),
        .vram_we     (vram_we),
        .cpu_reset   (cpu_reset)
    );

    // Behavioural SRAM: one-cycle read latency, synchronous write.
    always @(posedge clk) begin
        if (mem_we) sram[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= sram[mem_raddr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_write(input logic [15:0] addr, input logic [15:0] data);
        dbg_we = 1'b1; dbg_waddr = addr; dbg_wdata = data;
        tick();
        dbg_we = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) tick();
        check_cnt++; if (ins_rd_rdy !== 1'b0) $display("[TB] FAIL rst_ins_rdy got %b want 0", ins_rd_rdy); else pass_cnt++;
        check_cnt++; if (dat_rd_rdy !== 1'b0) $display("[TB] FAIL rst_dat_rd_rdy got %b want 0", dat_rd_rdy); else pass_cnt++;
        check_cnt++; if (dat_wr_rdy !== 1'b0) $display("[TB] FAIL rst_dat_wr_rdy got %b want 0", dat_wr_rdy); else pass_cnt++;
        check_cnt++; if (cpu_reset !== 1'b0) $display("[TB] FAIL rst_cpu_reset got %b want 0", cpu_reset); else pass_cnt++;
        check_cnt++; if (ins_rd_data !== 16'h0) $display("[TB] FAIL rst_ins_data got %h want 0000", ins_rd_data); else pass_cnt++;
        check_cnt++; if (dat_rd_data !== 16'h0) $display("[TB] FAIL rst_dat_data got %h want 0000", dat_rd_data); else pass_cnt++;
        check_cnt++; if ({mem_re, mem_we, vram_we} !== 3'b000) $display("[TB] FAIL rst_strobes got %b want 000", {mem_re, mem_we, vram_we}); else pass_cnt++;
        #2 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_preload;
        dbg_we = 1'b1; dbg_waddr = 16'h0010; dbg_wdata = 16'h1234;
        #1;
        check_cnt++; if (mem_we !== 1'b1 || mem_waddr !== 8'h10 || mem_wdata !== 16'h1234)
            $display("[TB] FAIL dbg_sram_wr got we=%b a=%h d=%h want we=1 a=10 d=1234", mem_we, mem_waddr, mem_wdata); else pass_cnt++;
        tick();
        dbg_we = 1'b0;
        dbg_write(16'h0020, 16'hBEEF);
    endtask

    task automatic test_uncontested;
        ins_rd_addr = 16'h0010; ins_rd_req = 1'b1;
        #1;
        check_cnt++; if (mem_re !== 1'b1 || mem_raddr !== 8'h10) $display("[TB] FAIL ins_grant got re=%b a=%h want re=1 a=10", mem_re, mem_raddr); else pass_cnt++;
        tick();
        ins_rd_req = 1'b0;
        check_cnt++; if (ins_rd_rdy !== 1'b1 || ins_rd_data !== 16'h1234) $display("[TB] FAIL ins_rdy got rdy=%b d=%h want rdy=1 d=1234", ins_rd_rdy, ins_rd_data); else pass_cnt++;
        tick();
        check_cnt++; if (ins_rd_rdy !== 1'b0) $display("[TB] FAIL ins_rdy_pulse got %b want 0", ins_rd_rdy); else pass_cnt++;
        dat_rw_addr = 16'h0020; dat_rd_req = 1'b1;
        #1;
        check_cnt++; if (mem_re !== 1'b1 || mem_raddr !== 8'h20) $display("[TB] FAIL dat_grant got re=%b a=%h want re=1 a=20", mem_re, mem_raddr); else pass_cnt++;
        tick();
        dat_rd_req = 1'b0;
        check_cnt++; if (dat_rd_rdy !== 1'b1 || dat_rd_data !== 16'hBEEF || ins_rd_rdy !== 1'b0)
            $display("[TB] FAIL dat_rdy got rdy=%b d=%h irdy=%b want 1 BEEF 0", dat_rd_rdy, dat_rd_data, ins_rd_rdy); else pass_cnt++;
        tick();
    endtask

    task automatic test_contention;
        logic exp_ins;
        logic prev_ins;
        prev_ins = 1'b0;
        ins_rd_addr = 16'h0010; ins_rd_req = 1'b1;
        dat_rw_addr = 16'h0020; dat_rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef CPU16_ARB_ROUND_ROBIN_EN
            exp_ins = (i % 2 == 0);
`else
            exp_ins = 1'b0;
`endif
            #1;
            check_cnt++; if (mem_re !== 1'b1 || mem_raddr !== (exp_ins ? 8'h10 : 8'h20))
                $display("[TB] FAIL contend_grant%0d got re=%b a=%h want a=%h", i, mem_re, mem_raddr, exp_ins ? 8'h10 : 8'h20); else pass_cnt++;
            if (i > 0) begin
                check_cnt++; if (ins_rd_rdy !== prev_ins || dat_rd_rdy !== !prev_ins)
                    $display("[TB] FAIL contend_rdy%0d got i=%b d=%b want i=%b", i, ins_rd_rdy, dat_rd_rdy, prev_ins); else pass_cnt++;
            end
            prev_ins = exp_ins;
            tick();
        end
        ins_rd_req = 1'b0; dat_rd_req = 1'b0;
        check_cnt++; if (ins_rd_rdy !== prev_ins || dat_rd_rdy !== !prev_ins || dat_rd_data !== (prev_ins ? 16'h0 : 16'hBEEF))
            $display("[TB] FAIL contend_last got i=%b d=%b dd=%h", ins_rd_rdy, dat_rd_rdy, dat_rd_data); else pass_cnt++;
        tick();
    endtask

    task automatic test_debug_priority;
        dbg_we = 1'b1; dbg_waddr = 16'h0005; dbg_wdata = 16'hAAAA;
        dat_wr_req = 1'b1; dat_rw_addr = 16'h0006; dat_wr_data = 16'h5555;
        #1;
        check_cnt++; if (mem_we !== 1'b1 || mem_waddr !== 8'h05 || mem_wdata !== 16'hAAAA)
            $display("[TB] FAIL dbgprio_n got we=%b a=%h d=%h want 1 05 AAAA", mem_we, mem_waddr, mem_wdata); else pass_cnt++;
        tick();
        dbg_we = 1'b0;
        #1;
        check_cnt++; if (dat_wr_rdy !== 1'b0 || mem_waddr !== 8'h06 || mem_wdata !== 16'h5555)
            $display("[TB] FAIL dbgprio_n1 got rdy=%b a=%h d=%h want 0 06 5555", dat_wr_rdy, mem_waddr, mem_wdata); else pass_cnt++;
        tick();
        dat_wr_req = 1'b0;
        check_cnt++; if (dat_wr_rdy !== 1'b1) $display("[TB] FAIL dbgprio_n2_rdy got %b want 1", dat_wr_rdy); else pass_cnt++;
        tick();
        check_cnt++; if (sram[5] !== 16'hAAAA || sram[6] !== 16'h5555)
            $display("[TB] FAIL dbgprio_sram got [5]=%h [6]=%h want AAAA 5555", sram[5], sram[6]); else pass_cnt++;
    endtask

    task automatic test_decode;
        dat_wr_req = 1'b1; dat_rw_addr = 16'h8123; dat_wr_data = 16'h00C1;
        #1;
        check_cnt++; if (vram_we !== 1'b1 || vram_waddr !== 11'h123 || vram_wdata !== 8'hC1 || mem_we !== 1'b0)
            $display("[TB] FAIL vram_wr got we=%b a=%h d=%h mwe=%b", vram_we, vram_waddr, vram_wdata, mem_we); else pass_cnt++;
        tick();
        dat_rw_addr = 16'h4000; dat_wr_data = 16'h7777;
        check_cnt++; if (dat_wr_rdy !== 1'b1) $display("[TB] FAIL vram_wr_rdy got %b want 1", dat_wr_rdy); else pass_cnt++;
        #1;
        check_cnt++; if (mem_we !== 1'b0 || vram_we !== 1'b0) $display("[TB] FAIL unmapped_wr got mwe=%b vwe=%b want 0 0", mem_we, vram_we); else pass_cnt++;
        tick();
        dat_wr_req = 1'b0;
        check_cnt++; if (dat_wr_rdy !== 1'b1) $display("[TB] FAIL unmapped_wr_rdy got %b want 1", dat_wr_rdy); else pass_cnt++;
        dat_rd_req = 1'b1;
        #1;
        check_cnt++; if (mem_re !== 1'b0) $display("[TB] FAIL unmapped_rd_re got %b want 0", mem_re); else pass_cnt++;
        tick();
        dat_rw_addr = 16'hF000;
        check_cnt++; if (dat_rd_rdy !== 1'b1 || dat_rd_data !== 16'hEEEE) $display("[TB] FAIL unmapped_rd got rdy=%b d=%h want 1 EEEE", dat_rd_rdy, dat_rd_data); else pass_cnt++;
        tick();
        dat_rd_req = 1'b0;
        check_cnt++; if (dat_rd_rdy !== 1'b1 || dat_rd_data !== 16'h0000) $display("[TB] FAIL ctrl_rd got rdy=%b d=%h want 1 0000", dat_rd_rdy, dat_rd_data); else pass_cnt++;
        tick();
        dat_rd_req = 1'b1; dat_wr_req = 1'b1; dat_rw_addr = 16'h0030; dat_wr_data = 16'h4242;
        #1;
        check_cnt++; if (mem_re !== 1'b0 || mem_we !== 1'b1) $display("[TB] FAIL rdwr_same got re=%b we=%b want 0 1", mem_re, mem_we); else pass_cnt++;
        tick();
        dat_wr_req = 1'b0;
        #1;
        check_cnt++; if (dat_wr_rdy !== 1'b1 || dat_rd_rdy !== 1'b0 || mem_re !== 1'b1 || mem_raddr !== 8'h30)
            $display("[TB] FAIL rdwr_next got wrdy=%b rrdy=%b re=%b a=%h", dat_wr_rdy, dat_rd_rdy, mem_re, mem_raddr); else pass_cnt++;
        tick();
        dat_rd_req = 1'b0;
        check_cnt++; if (dat_rd_rdy !== 1'b1 || dat_rd_data !== 16'h4242) $display("[TB] FAIL rdwr_data got rdy=%b d=%h want 1 4242", dat_rd_rdy, dat_rd_data); else pass_cnt++;
        tick();
    endtask

    task automatic test_ctrl;
        dbg_we = 1'b1; dbg_waddr = 16'hF000; dbg_wdata = 16'h0001;
        ins_rd_addr = 16'h0010; ins_rd_req = 1'b1;
        #1;
        check_cnt++; if (mem_re !== 1'b1) $display("[TB] FAIL ctrl_pre_grant got %b want 1", mem_re); else pass_cnt++;
        tick();
        dbg_we = 1'b0; dat_rw_addr = 16'h0020; dat_rd_req = 1'b1;
        #1;
        check_cnt++; if (cpu_reset !== 1'b1 || ins_rd_rdy !== 1'b0 || mem_re !== 1'b0)
            $display("[TB] FAIL ctrl_hold got crst=%b rdy=%b re=%b want 1 0 0", cpu_reset, ins_rd_rdy, mem_re); else pass_cnt++;
        tick();
        check_cnt++; if (ins_rd_rdy !== 1'b0 || dat_rd_rdy !== 1'b0) $display("[TB] FAIL ctrl_no_rdy got i=%b d=%b want 0 0", ins_rd_rdy, dat_rd_rdy); else pass_cnt++;
        dat_rd_req = 1'b0;
        dbg_we = 1'b1; dbg_wdata = 16'h0000;
        #1;
        check_cnt++; if (mem_re !== 1'b0) $display("[TB] FAIL ctrl_release_same got re=%b want 0", mem_re); else pass_cnt++;
        tick();
        dbg_we = 1'b0;
        #1;
        check_cnt++; if (cpu_reset !== 1'b0 || mem_re !== 1'b1 || mem_raddr !== 8'h10)
            $display("[TB] FAIL ctrl_resume got crst=%b re=%b a=%h want 0 1 10", cpu_reset, mem_re, mem_raddr); else pass_cnt++;
        tick();
        ins_rd_req = 1'b0;
        check_cnt++; if (ins_rd_rdy !== 1'b1 || ins_rd_data !== 16'h1234) $display("[TB] FAIL ctrl_resume_rdy got rdy=%b d=%h want 1 1234", ins_rd_rdy, ins_rd_data); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid;
        dbg_write(16'hF000, 16'h0001);
        check_cnt++; if (cpu_reset !== 1'b1) $display("[TB] FAIL rstmid_set got %b want 1", cpu_reset); else pass_cnt++;
        reset_n = 1'b0;
        #1;
        check_cnt++; if (cpu_reset !== 1'b0) $display("[TB] FAIL rstmid_crst got %b want 0", cpu_reset); else pass_cnt++;
        reset_n = 1'b1;
        tick();
        ins_rd_addr = 16'h0010; ins_rd_req = 1'b1;
        #1;
        check_cnt++; if (mem_re !== 1'b1) $display("[TB] FAIL rstmid_grant got %b want 1", mem_re); else pass_cnt++;
        tick();
        ins_rd_req = 1'b0;
        reset_n = 1'b0;
        #1;
        check_cnt++; if (ins_rd_rdy !== 1'b0 || ins_rd_data !== 16'h0 || mem_re !== 1'b0 || cpu_reset !== 1'b0)
            $display("[TB] FAIL rstmid_outs got rdy=%b d=%h re=%b crst=%b", ins_rd_rdy, ins_rd_data, mem_re, cpu_reset); else pass_cnt++;
        #2 reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_cnt++; if (ins_rd_rdy !== 1'b0 || dat_rd_rdy !== 1'b0) $display("[TB] FAIL rstmid_after%0d got i=%b d=%b want 0 0", i, ins_rd_rdy, dat_rd_rdy); else pass_cnt++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 16'h0000;
        test_reset();
        test_preload();
        test_uncontested();
        test_contention();
        test_debug_priority();
        test_decode();
        test_ctrl();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
